// File: rtl/tile_rect_drawer.sv
// Rasterises one clipped, axis-aligned filled rectangle per request into a
// one-pixel-per-clock VGA plot stream, with a start/busy/done handshake.
module tile_rect_drawer #(
  parameter int unsigned H_RES = 640,
  parameter int unsigned V_RES = 480
) (
  input  logic        CLOCK_50,
  input  logic        resetn,
  input  logic        start,
  input  logic [9:0]  x0,
  input  logic [8:0]  y0,
  input  logic [9:0]  width,
  input  logic [8:0]  height,
  input  logic [23:0] color,
  output logic        busy,
  output logic        done,
  output logic [9:0]  VGA_X,
  output logic [8:0]  VGA_Y,
  output logic [23:0] VGA_COLOR,
  output logic        plot
);

  typedef enum logic [1:0] {IDLE, DRAW, FINISH} state_t;

  state_t      state, state_next;
  logic [9:0]  x_lat, w_lat, cx;
  logic [8:0]  y_lat, h_lat, cy;
  logic [23:0] color_lat;
  logic [10:0] x_room;
  logic [9:0]  y_room;
  logic [9:0]  w_clip;
  logic [8:0]  h_clip;
  logic        row_end, last_pixel;

  // Room to the screen edge uses one extra bit so width/height never wrap.
  always_comb begin
    x_room = '0;
    y_room = '0;
    w_clip = '0;
    h_clip = '0;
    if ({1'b0, x0} < 11'(H_RES)) begin
      x_room = 11'(H_RES) - {1'b0, x0};
      w_clip = ({1'b0, width} < x_room) ? width : x_room[9:0];
    end
    if ({1'b0, y0} < 10'(V_RES)) begin
      y_room = 10'(V_RES) - {1'b0, y0};
      h_clip = ({1'b0, height} < y_room) ? height : y_room[8:0];
    end
  end

  assign row_end    = (cx == w_lat - 10'd1);
  assign last_pixel = row_end && (cy == h_lat - 9'd1);

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start)
          state_next = (w_clip == '0 || h_clip == '0) ? FINISH : DRAW;
      end
      DRAW: begin
        if (last_pixel)
          state_next = FINISH;
      end
      FINISH: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      plot      <= 1'b0;
      VGA_X     <= '0;
      VGA_Y     <= '0;
      VGA_COLOR <= '0;
      x_lat     <= '0;
      y_lat     <= '0;
      w_lat     <= '0;
      h_lat     <= '0;
      cx        <= '0;
      cy        <= '0;
      color_lat <= '0;
    end else begin
      state <= state_next;
      plot  <= (state == DRAW);
      busy  <= (state == DRAW);
      done  <= (state == FINISH);
      case (state)
        IDLE: begin
          if (start) begin
            x_lat     <= x0;
            y_lat     <= y0;
            w_lat     <= w_clip;
            h_lat     <= h_clip;
            color_lat <= color;
            cx        <= '0;
            cy        <= '0;
          end
        end
        DRAW: begin
          VGA_X     <= x_lat + cx;
          VGA_Y     <= y_lat + cy;
          VGA_COLOR <= color_lat;
          if (row_end) begin
            cx <= '0;
            cy <= cy + 9'd1;
          end else begin
            cx <= cx + 10'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/tile_rect_drawer.md
Name: tile_rect_drawer

Overview:
- Rasterises one axis-aligned filled rectangle per request (a piano tile, a lane divider, or a full-screen clear) into the pixel-write stream consumed by the DESim VGA port (VGA_X, VGA_Y, VGA_COLOR, plot).
- Sits between the game-logic FSM, which issues draw/erase requests, and the top-level VGA outputs.
- Emits one pixel per clock. Uses a start/busy/done handshake.

Parameters:
- H_RES, 640, visible columns; x coordinates at or above this are clipped.
- V_RES, 480, visible rows; y coordinates at or above this are clipped.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz; all logic on its rising edge.
- resetn  in  1  reset; one clock; reset is synchronous and active-low.
- start  in  1  request strobe; sampled only when busy=0.
- x0  in  10  left column of the rectangle.
- y0  in  9  top row of the rectangle.
- width  in  10  width in pixels, 0..1023.
- height  in  9  height in pixels, 0..511.
- color  in  24  RGB888 fill colour.
- busy  out  1  high from the cycle after acceptance until done is asserted.
- done  out  1  one-cycle pulse when the request is complete.
- VGA_X  out  10  pixel column.
- VGA_Y  out  9  pixel row.
- VGA_COLOR  out  24  pixel colour.
- plot  out  1  VGA_X, VGA_Y and VGA_COLOR are a valid pixel write this cycle.

Behaviour:
- Reset (resetn=0 at an edge):
  - State goes to IDLE.
  - busy=0, done=0, plot=0, VGA_X=0, VGA_Y=0, VGA_COLOR=0.
  - Reset mid-draw aborts immediately: no further plot, and no done for the aborted request.
- State IDLE:
  - If start=1, latch x0, y0 and color, plus the clipped extents:
    - w_eff = min(width, H_RES - x0), or 0 if x0 >= H_RES.
    - h_eff = min(height, V_RES - y0), or 0 if y0 >= V_RES.
  - Compute the extents with width+1-bit arithmetic so nothing wraps.
  - If w_eff=0 or h_eff=0, go to FINISH. Otherwise go to DRAW, with column counter cx=0 and row counter cy=0.
  - start=0 in IDLE: stay in IDLE with all outputs low.
- State DRAW:
  - Each cycle register plot=1, VGA_X=x_lat+cx, VGA_Y=y_lat+cy, VGA_COLOR=color_lat.
  - Scan is row-major. When cx=w_eff-1, cx wraps to 0 and cy increments.
  - After pixel (w_eff-1, h_eff-1), go to FINISH.
  - Exactly w_eff*h_eff plot pulses, on consecutive cycles with no gaps.
  - Clipping guarantees VGA_X < H_RES and VGA_Y < V_RES on every plot.
- State FINISH:
  - One cycle: done=1, plot=0, busy=0. Then return to IDLE.
  - start during FINISH is ignored.
- Latency:
  - Request accepted at edge N.
  - First plot and busy=1 are visible after edge N+1.
  - Last plot is visible after edge N+w_eff*h_eff.
  - done is visible after edge N+w_eff*h_eff+1.
  - Zero-area request: done is visible after edge N+1, with no plot and busy staying 0.
- Input handling:
  - start while busy=1 is ignored.
  - Inputs changing during DRAW have no effect, since all request data is latched.
- Output rules:
  - When plot=0, VGA_X, VGA_Y and VGA_COLOR hold their last values.
  - Consumers must qualify them with plot.
- Back-to-back requests:
  - start held high through FINISH is accepted in the following IDLE cycle.
  - The minimum gap between requests is therefore one idle cycle after done.

Test Plan:
- Reset then idle: resetn=0 for 2 cycles, then start=0 for 10 cycles -> plot, busy and done stay 0; VGA_X=0, VGA_Y=0, VGA_COLOR=0.
- 3x2 tile at (100,50), color=24'hFFFFFF:
  - plot high for exactly 6 consecutive cycles.
  - Coordinates in order: (100,50) (101,50) (102,50) (100,51) (101,51) (102,51).
  - done pulses one cycle after the last plot; busy high for exactly 6 cycles.
- Clipping, x0=638, y0=478, width=5, height=5 -> exactly 4 plots: (638,478) (639,478) (638,479) (639,479).
- Zero and off-screen requests, each followed by a done pulse with no plot:
  - width=0.
  - x0=700.
  - y0=480, height=10.
- Reset mid-draw and back-to-back:
  - 160x120 draw, resetn=0 after 37 plots -> no plot or done afterwards; next request 1x1 at (0,0) yields exactly one plot.
  - Two 2x2 requests with start held high -> second request's first plot appears exactly 2 cycles after the first request's done.
- Busy ignore: 4x4 request, then start=1 with a different colour mid-draw -> all 16 plots use the first colour; only one done.
